adder3b: RTL and testbench
==========================

// Module: adder3b
// PURPOSE
//  - Single-bit full adder: adds three 1-bit operands a, b, c; produces sum and carry.
//  - Combinational sum/carry for direct use in ripple-carry chains.
//  - Registered copies with a valid flag, plus a saturating carry-event counter, for pipelined datapaths and debug.
//  - Leaf cell; no internal submodules required.
// PARAMETERS
//  - CNT_W  8  width of carry-event counter carry_cnt (>=1)
// PORTS
//  - clk        in   1      single clock; all state updates on rising edge
//  - rst        in   1      reset, synchronous, active-high
//  - a          in   1      operand bit A
//  - b          in   1      operand bit B
//  - c          in   1      carry-in / operand bit C
//  - in_valid   in   1      qualifies a/b/c for the registered path and the counter
//  - sum        out  1      combinational a ^ b ^ c
//  - carry      out  1      combinational majority(a,b,c) = (a&b)|(a&c)|(b&c)
//  - sum_q      out  1      registered sum
//  - carry_q    out  1      registered carry
//  - valid_q    out  1      registered in_valid
//  - carry_cnt  out  CNT_W  count of valid cycles with carry=1, saturating
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous and active-high.
//  - sum/carry: purely combinational and independent of clk, rst and in_valid.
//    They follow a/b/c after propagation delay only and are valid during reset.
//  - Arithmetic: {carry,sum} = a + b + c (2-bit result, range 0..3).
//    Full truth table, index {a,b,c}:
//    000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11 ({carry,sum}).
//  - Registered path: latency 1 cycle.
//    Each rising edge with rst=0: valid_q<=in_valid.
//    When in_valid=1, sum_q<=sum and carry_q<=carry; when in_valid=0, sum_q/carry_q hold their value.
//  - Counter: on each rising edge with rst=0, in_valid=1 and carry=1, carry_cnt increments by 1.
//    It saturates at 2^CNT_W-1; no wrap-around. Otherwise it holds.
//  - Reset (rst=1 at rising edge): sum_q=0, carry_q=0, valid_q=0, carry_cnt=0.
//    Reset takes priority over in_valid; mid-stream reset discards the in-flight sample.
//  - Outputs sum_q/carry_q/valid_q/carry_cnt are X-free after the first reset edge.
//  - No handshake backpressure: every valid input is accepted each cycle.
// TESTING
//  - Exhaustive comb: apply {a,b,c}=0..7, 5 time units apart, in_valid=0.
//    Expect sum=1 for 1,2,4,7 and carry=1 for 3,5,6,7; else 0.
//  - Registered latency: rst for 2 cycles, then in_valid=1 with {a,b,c}=3'b111.
//    Next edge: sum_q=1, carry_q=1, valid_q=1. A following in_valid=0 cycle -> valid_q=0, sum_q/carry_q hold 1.
//  - Counter: after reset, drive valid inputs 011,101,110,001.
//    Expect carry_cnt=3 after the 4th edge.
//  - Saturation: CNT_W=2, drive 5 valid cycles of 111.
//    Expect carry_cnt = 1,2,3,3,3.
//  - Reset mid-operation: rst=1 together with in_valid=1 and 111.
//    Next edge: all registered outputs 0, carry_cnt=0; comb sum=1, carry=1 throughout.

Source files
------------

// File: rtl/adder3b.sv
// ---------------------------------------------------------------------------
// adder3b -- single-bit full adder leaf cell
//
// Purpose:
//   Adds three 1-bit operands (a, b, c) and produces sum/carry both
//   combinationally (for ripple-carry chains) and as registered copies with
//   a valid flag. A saturating counter tallies valid cycles whose carry is 1.
//
// Parameters:
//   CNT_W      width of the carry-event counter (>= 1)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   a, b, c    in   1      operand bits (c doubles as carry-in)
//   in_valid   in   1      qualifies a/b/c for the registered path/counter
//   sum        out  1      combinational a ^ b ^ c
//   carry      out  1      combinational majority(a, b, c)
//   sum_q      out  1      registered sum (holds when in_valid=0)
//   carry_q    out  1      registered carry (holds when in_valid=0)
//   valid_q    out  1      registered in_valid
//   carry_cnt  out  CNT_W  saturating count of valid cycles with carry=1
// ---------------------------------------------------------------------------
module adder3b #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             in_valid,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] carry_cnt
);

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    logic             w_sum_p0;
    logic             w_carry_p0;
    logic             r_sum_p1;
    logic             r_carry_p1;
    logic             r_vld_p1;
    logic [CNT_W-1:0] r_cnt_p1;

    // Stage p0: combinational full adder, independent of clk/rst/in_valid.
    always_comb begin
        w_sum_p0   = a ^ b ^ c;
        w_carry_p0 = (a & b) | (a & c) | (b & c);
    end

    // Stage p1: registered result, valid flag and carry-event counter.
    // Reset has priority, so a sample presented alongside rst is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_p1   <= 1'b0;
            r_carry_p1 <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_cnt_p1   <= '0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_sum_p1   <= w_sum_p0;
                r_carry_p1 <= w_carry_p0;
                if (w_carry_p0) begin
                    r_cnt_p1 <= sat_inc(r_cnt_p1);
                end
            end
        end
    end

    assign sum       = w_sum_p0;
    assign carry     = w_carry_p0;
    assign sum_q     = r_sum_p1;
    assign carry_q   = r_carry_p1;
    assign valid_q   = r_vld_p1;
    assign carry_cnt = r_cnt_p1;

endmodule

// File: tb/tb_adder3b.sv
module tb_adder3b;

    logic       clk;
    logic       rst;
    logic       a, b, c;
    logic       in_valid;

    logic       sum8, carry8, sum_q8, carry_q8, valid_q8;
    logic [7:0] cnt8;
    logic       sum2, carry2, sum_q2, carry_q2, valid_q2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    // Reference model state (plain integers)
    int m_sum_q, m_carry_q, m_valid_q, m_cnt8, m_cnt2;

    typedef struct {
        logic [2:0] abc;
        logic       exp_sum;
        logic       exp_carry;
    } vec_t;

    vec_t tbl[8];

    adder3b #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
        .valid_q(valid_q8), .carry_cnt(cnt8)
    );

    adder3b #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .sum(sum2), .carry(carry2), .sum_q(sum_q2), .carry_q(carry_q2),
        .valid_q(valid_q2), .carry_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] abc);
        rst      = r;
        in_valid = v;
        {a, b, c} = abc;
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model update for one rising edge using the current inputs.
    task automatic model_edge();
        int total;
        total = int'(a) + int'(b) + int'(c);
        if (rst) begin
            m_sum_q = 0; m_carry_q = 0; m_valid_q = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_valid_q = int'(in_valid);
            if (in_valid) begin
                m_sum_q   = total % 2;
                m_carry_q = total / 2;
                if (total >= 2) begin
                    m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
                    m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
                end
            end
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".sum_q"},   int'(sum_q8),   m_sum_q);
        chk({tag, ".carry_q"}, int'(carry_q8), m_carry_q);
        chk({tag, ".valid_q"}, int'(valid_q8), m_valid_q);
        chk({tag, ".cnt8"},    int'(cnt8),     m_cnt8);
        chk({tag, ".cnt2"},    int'(cnt2),     m_cnt2);
        chk({tag, ".sum_q2"},  int'(sum_q2),   m_sum_q);
        chk({tag, ".valid_q2"}, int'(valid_q2), m_valid_q);
    endtask

    initial begin
        logic [2:0] r_abc;
        int         tot;

        tbl[0] = '{3'b000, 1'b0, 1'b0};
        tbl[1] = '{3'b001, 1'b1, 1'b0};
        tbl[2] = '{3'b010, 1'b1, 1'b0};
        tbl[3] = '{3'b011, 1'b0, 1'b1};
        tbl[4] = '{3'b100, 1'b1, 1'b0};
        tbl[5] = '{3'b101, 1'b0, 1'b1};
        tbl[6] = '{3'b110, 1'b0, 1'b1};
        tbl[7] = '{3'b111, 1'b1, 1'b1};

        drive(1'b1, 1'b0, 3'b000);
        m_sum_q = 0; m_carry_q = 0; m_valid_q = 0; m_cnt8 = 0; m_cnt2 = 0;

        // Two reset cycles, then check the reset state
        step();
        step();
        chk_regs("reset");

        // Exhaustive combinational table, in_valid=0, 5 time units apart
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b0;
            {a, b, c} = tbl[i].abc;
            #1;
            chk($sformatf("comb%0d.sum", i),    int'(sum8),   int'(tbl[i].exp_sum));
            chk($sformatf("comb%0d.carry", i),  int'(carry8), int'(tbl[i].exp_carry));
            chk($sformatf("comb%0d.sum2", i),   int'(sum2),   int'(tbl[i].exp_sum));
            #4;
        end

        // Registered latency: reset 2 cycles, then one valid 111
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b000);
        step(); step();
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b111);
        step();
        chk("lat.sum_q", int'(sum_q8), 1);
        chk("lat.carry_q", int'(carry_q8), 1);
        chk("lat.valid_q", int'(valid_q8), 1);
        drive(1'b0, 1'b0, 3'b000);
        step();
        chk("lat.idle_valid_q", int'(valid_q8), 0);
        chk("lat.hold_sum_q", int'(sum_q8), 1);
        chk("lat.hold_carry_q", int'(carry_q8), 1);

        // Counter: 011,101,110,001 after reset -> 3
        drive(1'b1, 1'b0, 3'b000);
        step();
        chk("cnt.reset", int'(cnt8), 0);
        drive(1'b0, 1'b1, 3'b011); step();
        drive(1'b0, 1'b1, 3'b101); step();
        drive(1'b0, 1'b1, 3'b110); step();
        drive(1'b0, 1'b1, 3'b001); step();
        chk("cnt.after4", int'(cnt8), 3);
        chk("cnt.sum_q_last", int'(sum_q8), 1);
        chk("cnt.carry_q_last", int'(carry_q8), 0);

        // Saturation on the CNT_W=2 instance: 1,2,3,3,3
        drive(1'b1, 1'b0, 3'b000);
        step();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b1, 3'b111);
            step();
            chk($sformatf("sat.cnt2_%0d", k), int'(cnt2), (k > 3) ? 3 : k);
            chk($sformatf("sat.cnt8_%0d", k), int'(cnt8), k);
        end

        // Mid-operation reset with a valid 111 presented
        drive(1'b1, 1'b1, 3'b111);
        #1;
        chk("rstmid.pre_sum", int'(sum8), 1);
        chk("rstmid.pre_carry", int'(carry8), 1);
        step();
        chk("rstmid.sum_q", int'(sum_q8), 0);
        chk("rstmid.carry_q", int'(carry_q8), 0);
        chk("rstmid.valid_q", int'(valid_q8), 0);
        chk("rstmid.cnt8", int'(cnt8), 0);
        chk("rstmid.cnt2", int'(cnt2), 0);
        chk("rstmid.post_sum", int'(sum8), 1);
        chk("rstmid.post_carry", int'(carry8), 1);

        // Randomized run against the arithmetic reference model
        m_sum_q = 0; m_carry_q = 0; m_valid_q = 0; m_cnt8 = 0; m_cnt2 = 0;
        for (int n = 0; n < 300; n++) begin
            r_abc = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  $urandom_range(0, 3) != 0 ? 1'b1 : 1'b0, r_abc);
            #1;
            tot = int'(r_abc[2]) + int'(r_abc[1]) + int'(r_abc[0]);
            chk("rnd.sum", int'(sum8), tot % 2);
            chk("rnd.carry", int'(carry8), tot / 2);
            model_edge();
            step();
            chk_regs("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
